s2_kes_ctrl: RTL

//  Scheduler in front of the stage-2 DCME key-equation solver (s2_kes_dcme2). Buffers syndrome sets from stage 1,

---
 rtl/s2_kes_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/s2_kes_ctrl.sv
// Stage-2 KES scheduler: buffers syndrome sets, launches one KES run per set, and
// presents lambda/omega (or a bypass/timeout result) on a valid/ready port to stage 3.
module s2_kes_ctrl #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       syn_valid,
    output logic       syn_ready,
    input  logic [7:0] syn0,
    input  logic [7:0] syn1,
    input  logic [7:0] syn2,
    input  logic [7:0] syn3,
    output logic       kes_ena,
    output logic [7:0] kes_syn0,
    output logic [7:0] kes_syn1,
    output logic [7:0] kes_syn2,
    output logic [7:0] kes_syn3,
    input  logic       kes_done,
    input  logic [7:0] kes_lambda0,
    input  logic [7:0] kes_lambda1,
    input  logic [7:0] kes_lambda2,
    input  logic [7:0] kes_omega0,
    input  logic [7:0] kes_omega1,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_lambda0,
    output logic [7:0] out_lambda1,
    output logic [7:0] out_lambda2,
    output logic [7:0] out_omega0,
    output logic [7:0] out_omega1,
    output logic       out_err,
    output logic       out_fail,
    output logic       busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        StIdle   = 4'b0001,
        StLaunch = 4'b0010,
        StWait   = 4'b0100,
        StOut    = 4'b1000
    } state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     head;
    logic            full, empty, push, pop;
    logic            ld_bypass, ld_done, ld_fail;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign syn_ready = ~full;
    assign push      = syn_valid & ~full;
    assign pop       = (state_q == StIdle) & ~empty;
    assign head      = mem[rd_ptr_q];
    assign kes_ena   = (state_q == StLaunch);
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle) | ~empty;

    // Storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {syn3, syn2, syn1, syn0};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        ld_bypass = 1'b0;
        ld_done   = 1'b0;
        ld_fail   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    ld_bypass = (head == '0);
                    state_d   = (head == '0) ? StOut : StLaunch;
                end
            end
            StLaunch: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                // A completion in the expiry cycle still counts as a good run.
                if (kes_done) begin
                    ld_done = 1'b1;
                    state_d = StOut;
                end else if (wdog_q == WW'(TIMEOUT)) begin
                    ld_fail = 1'b1;
                    state_d = StOut;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            StOut: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            kes_syn0 <= '0;
            kes_syn1 <= '0;
            kes_syn2 <= '0;
            kes_syn3 <= '0;
        end else if (pop) begin
            {kes_syn3, kes_syn2, kes_syn1, kes_syn0} <= head;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_lambda0 <= '0;
            out_lambda1 <= '0;
            out_lambda2 <= '0;
            out_omega0  <= '0;
            out_omega1  <= '0;
            out_err     <= 1'b0;
            out_fail    <= 1'b0;
        end else if (ld_bypass) begin
            out_lambda0 <= 8'h01;
            out_lambda1 <= '0;
            out_lambda2 <= '0;
            out_omega0  <= '0;
            out_omega1  <= '0;
            out_err     <= 1'b0;
            out_fail    <= 1'b0;
        end else if (ld_done) begin
            out_lambda0 <= kes_lambda0;
            out_lambda1 <= kes_lambda1;
            out_lambda2 <= kes_lambda2;
            out_omega0  <= kes_omega0;
            out_omega1  <= kes_omega1;
            out_err     <= 1'b1;
            out_fail    <= 1'b0;
        end else if (ld_fail) begin
            out_lambda0 <= '0;
            out_lambda1 <= '0;
            out_lambda2 <= '0;
            out_omega0  <= '0;
            out_omega1  <= '0;
            out_err     <= 1'b1;
            out_fail    <= 1'b1;
        end
    end

endmodule
